// File: rtl/dadda_pkg.sv
// Shared types and widths for the arbitrated 4x4 Dadda multiplier.
package dadda_pkg;

  localparam int NREQ   = 4;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dadda.sv
// Unsigned 4x4 Dadda multiplier: two reduction stages (heights 3, then 2) and a final adder.
module dadda
  import dadda_pkg::*;
(
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic [PROD_W-1:0] p
);

  // pp[i][j] has weight i+j
  logic [3:0] pp [0:3];
  logic s1, c1, s2, c2, s3, c3, s4, c4, s5, c5, s6, c6;
  logic [PROD_W-1:0] row_x, row_y;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[i][j] = a[j] & b[i];
      end
    end
  end

  assign {c1, s1} = {1'b0, pp[0][3]} + {1'b0, pp[1][2]};
  assign {c2, s2} = {1'b0, pp[1][3]} + {1'b0, pp[2][2]};

  assign {c3, s3} = {1'b0, pp[0][2]} + {1'b0, pp[1][1]};
  assign {c4, s4} = {1'b0, s1} + {1'b0, pp[2][1]} + {1'b0, pp[3][0]};
  assign {c5, s5} = {1'b0, s2} + {1'b0, pp[3][1]} + {1'b0, c1};
  assign {c6, s6} = {1'b0, pp[2][3]} + {1'b0, pp[3][2]} + {1'b0, c2};

  assign row_x = {1'b0, pp[3][3], s6, s5, s4, s3, pp[0][1], pp[0][0]};
  assign row_y = {1'b0, c6, c5, c4, c3, pp[2][0], pp[1][0], 1'b0};
  assign p     = row_x + row_y;

endmodule

// File: rtl/rr_grant4.sv
// Four-way round-robin winner search starting at ptr and wrapping mod 4.
module rr_grant4
  import dadda_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id
);

  logic [1:0] idx;
  logic       found;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dadda_arb.sv
// Round-robin arbiter feeding a shared 4x4 Dadda multiplier with a valid/ready response port.
module dadda_arb #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  output logic [1:0]        resp_id,
  output logic [7:0]        resp_p,
  input  logic              resp_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  import dadda_pkg::*;

  state_e              state_q, state_d;
  logic [1:0]          ptr_q, ptr_d;
  logic [OP_W-1:0]     op_a_q, op_a_d;
  logic [OP_W-1:0]     op_b_q, op_b_d;
  logic [1:0]          op_id_q, op_id_d;
  logic                resp_valid_q, resp_valid_d;
  logic [1:0]          resp_id_q, resp_id_d;
  logic [PROD_W-1:0]   resp_p_q, resp_p_d;
  logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;
  logic                busy_q, busy_d;

  logic [3:0]          gnt;
  logic [1:0]          gnt_id;
  logic [PROD_W-1:0]   prod;

  rr_grant4 u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  dadda u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (prod)
  );

  // Grants are only offered while idle, so at most one operation is in flight.
  assign req_ready = (state_q == IDLE) ? gnt : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_p_d     = resp_p_q;
    done_cnt_d   = done_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req_ready) begin
          state_d = MUL;
          op_a_d  = req_a[{gnt_id, 2'b00} +: OP_W];
          op_b_d  = req_b[{gnt_id, 2'b00} +: OP_W];
          op_id_d = gnt_id;
        end
      end
      MUL: begin
        resp_p_d     = prod;
        resp_id_d    = op_id_q;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        // Pointer moves past the served requester only once the response is consumed.
        if (resp_valid_q && resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
          ptr_d        = op_id_q + 2'd1;
          done_cnt_d   = done_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_id_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_p_q     <= '0;
      done_cnt_q   <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_p_q     <= resp_p_d;
      done_cnt_q   <= done_cnt_d;
      busy_q       <= busy_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_p     = resp_p_q;
  assign done_cnt   = done_cnt_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_dadda_arb.sv
// Directed self-checking bench for dadda_arb with hand-computed products and grant orders.
module tb_dadda_arb;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [1:0]  resp_id;
  logic [7:0]  resp_p;
  logic        resp_ready;
  logic        busy;
  logic [15:0] done_cnt;

  int checks   = 0;
  int failures = 0;

  dadda_arb #(.NREQ(4), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_p     (resp_p),
    .resp_ready (resp_ready),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Accept edge, multiply edge, then check the pending response before the handshake edge.
  task automatic serveOne(input string tag, input logic [1:0] exp_id, input logic [7:0] exp_p);
    tick();
    checkOutput({tag, "_busy"}, busy, 1);
    checkOutput({tag, "_early_valid"}, resp_valid, 0);
    tick();
    checkOutput({tag, "_valid"}, resp_valid, 1);
    checkOutput({tag, "_id"}, resp_id, exp_id);
    checkOutput({tag, "_p"}, resp_p, exp_p);
    tick();
    checkOutput({tag, "_done_valid"}, resp_valid, 0);
  endtask

  logic [3:0]  exp_gnt;
  logic [7:0]  exp_prod;

  initial begin
    rst        = 1'b1;
    resp_ready = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    tick();
    tick();
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done_cnt", done_cnt, 0);
    checkOutput("rst_resp_p", resp_p, 0);
    checkOutput("rst_resp_id", resp_id, 0);
    checkOutput("rst_req_ready", req_ready, 0);
    rst = 1'b0;
    #1;

    // Single request from requester 0: 7*9
    resp_ready = 1'b1;
    applyStimulus(4'b0001, 16'h0007, 16'h0009);
    checkOutput("single_gnt", req_ready, 4'b0001);
    serveOne("single", 2'd0, 8'd63);
    applyStimulus(4'b0000, 16'h0000, 16'h0000);
    checkOutput("single_cnt", done_cnt, 1);

    // All four requesting from ptr 0: served in id order
    doReset();
    applyStimulus(4'b1111, 16'hC0F3, 16'h49F5);
    for (int k = 0; k < 4; k++) begin
      exp_gnt = 4'b0001 << k;
      case (k)
        0: exp_prod = 8'd15;
        1: exp_prod = 8'd225;
        2: exp_prod = 8'd0;
        default: exp_prod = 8'd48;
      endcase
      checkOutput("all4_gnt", req_ready, exp_gnt);
      serveOne("all4", 2'(k), exp_prod);
    end
    applyStimulus(4'b0000, 16'h0000, 16'h0000);
    checkOutput("all4_cnt", done_cnt, 4);

    // Wrap: after id3 the pointer is back at 0
    applyStimulus(4'b1001, 16'h1002, 16'h5003);
    checkOutput("wrap_gnt0", req_ready, 4'b0001);
    serveOne("wrap0", 2'd0, 8'd6);
    checkOutput("wrap_gnt3", req_ready, 4'b1000);
    serveOne("wrap3", 2'd3, 8'd5);
    applyStimulus(4'b0000, 16'h0000, 16'h0000);
    checkOutput("wrap_cnt", done_cnt, 6);

    // Backpressure on requester 1, with other traffic and operand churn meanwhile
    resp_ready = 1'b0;
    applyStimulus(4'b0010, 16'h00A0, 16'h00B0);
    checkOutput("bp_gnt", req_ready, 4'b0010);
    tick();
    applyStimulus(4'b0110, 16'h0350, 16'h0730);
    checkOutput("bp_mul_ready", req_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_valid", resp_valid, 1);
      checkOutput("bp_p", resp_p, 8'd110);
      checkOutput("bp_id", resp_id, 2'd1);
      checkOutput("bp_req_ready", req_ready, 0);
      checkOutput("bp_cnt_hold", done_cnt, 6);
      tick();
    end
    resp_ready = 1'b1;
    applyStimulus(4'b0000, 16'h0000, 16'h0000);
    tick();
    checkOutput("bp_release_valid", resp_valid, 0);
    checkOutput("bp_cnt", done_cnt, 7);
    checkOutput("bp_idle", busy, 0);

    // A request that drops before any edge is never accepted
    applyStimulus(4'b0100, 16'h0F00, 16'h0F00);
    applyStimulus(4'b0000, 16'h0F00, 16'h0F00);
    tick();
    checkOutput("drop_busy", busy, 0);
    checkOutput("drop_cnt", done_cnt, 7);

    // Reset while a 6*7 response is pending on requester 2 (ptr is 2 here)
    resp_ready = 1'b0;
    applyStimulus(4'b0100, 16'h0600, 16'h0700);
    tick();
    tick();
    applyStimulus(4'b0000, 16'h0000, 16'h0000);
    checkOutput("rr_pending_valid", resp_valid, 1);
    checkOutput("rr_pending_p", resp_p, 8'd42);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rr_valid", resp_valid, 0);
    checkOutput("rr_cnt", done_cnt, 0);
    checkOutput("rr_busy", busy, 0);
    checkOutput("rr_p", resp_p, 0);
    tick();
    rst = 1'b0;
    resp_ready = 1'b1;
    applyStimulus(4'b1111, 16'h0000, 16'h0000);
    checkOutput("rr_first_gnt", req_ready, 4'b0001);
    applyStimulus(4'b0000, 16'h0000, 16'h0000);
    tick();
    checkOutput("rr_cnt_after", done_cnt, 0);

    // Exhaustive operand sweep through requester 2
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        applyStimulus(4'b0100, 16'(a) << 8, 16'(b) << 8);
        tick();
        tick();
        exp_prod = 8'(a * b);
        checkOutput("exh_p", resp_p, exp_prod);
        checkOutput("exh_id", resp_id, 2'd2);
        tick();
      end
    end
    applyStimulus(4'b0000, 16'h0000, 16'h0000);
    checkOutput("exh_cnt", done_cnt, 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
